// File: rtl/mem_map_decoder.sv
// CPU address decoder: range-matched regions, per-region wait states, sticky unmapped-access error.
// Latency W+1 cycles for a region with W wait states; cpu_ready low stalls the CPU, which holds its request.
module mem_map_decoder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N_REG  = 4,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE  = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [N_REG*ADDR_W-1:0] REG_LIMIT = {16'h30FF, 16'h2960, 16'h10FF, 16'h07FF},
    parameter logic [N_REG*4-1:0]      REG_WAIT  = {4'd1, 4'd2, 4'd0, 4'd0}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic                    cpu_we,
    input  logic                    cpu_re,
    output logic                    cpu_ready,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic [N_REG-1:0]        slv_we,
    output logic [N_REG-1:0]        slv_re,
    input  logic [N_REG*DATA_W-1:0] slv_rdata,
    input  logic                    err_clr,
    output logic                    err_flag,
    output logic [ADDR_W-1:0]       err_addr
);
    localparam int IW = $clog2(N_REG + 1);
    localparam logic [IW-1:0] NONE = IW'(N_REG);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IW-1:0]     reg_q, reg_d;
    logic [IW-1:0]     rsel_q, rsel_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              access;
    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic [3:0]        hit_wait;
    logic              done;
    logic              done_hit;
    logic [IW-1:0]     done_idx;

    assign access = cpu_we | cpu_re;

    // Scan high to low so the lowest matching region overrides.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = NONE;
        hit_wait = 4'd0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (cpu_addr >= REG_BASE[i*ADDR_W +: ADDR_W] &&
                cpu_addr <= REG_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_wait = REG_WAIT[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            reg_q      <= NONE;
            rsel_q     <= NONE;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reg_q      <= reg_d;
            rsel_q     <= rsel_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        case (state_q)
            ST_IDLE: begin
                if (access && hit && hit_wait != 4'd0) begin
                    state_d = ST_WAIT;
                    cnt_d   = hit_wait;
                    reg_d   = hit_idx;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In WAIT the region comes from the latch, not the live decode.
    always_comb begin
        done     = 1'b0;
        done_hit = 1'b0;
        done_idx = NONE;
        case (state_q)
            ST_IDLE: begin
                if (access && !hit) begin
                    done = 1'b1;
                end else if (access && hit_wait == 4'd0) begin
                    done     = 1'b1;
                    done_hit = 1'b1;
                    done_idx = hit_idx;
                end
            end
            ST_WAIT: begin
                if (access && cnt_q <= 4'd1) begin
                    done     = 1'b1;
                    done_hit = 1'b1;
                    done_idx = reg_q;
                end
            end
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        cpu_ready = done & ~rst;
        for (int i = 0; i < N_REG; i++) begin
            slv_we[i] = cpu_ready & done_hit & (done_idx == IW'(i)) & cpu_we;
            slv_re[i] = cpu_ready & done_hit & (done_idx == IW'(i)) & cpu_re & ~cpu_we;
        end
    end

    always_comb begin
        rsel_d     = rsel_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (cpu_ready && cpu_re && !cpu_we) begin
            rsel_d = done_idx;
        end
        if (cpu_ready && !done_hit) begin
            err_flag_d = 1'b1;
            err_addr_d = cpu_addr;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    always_comb begin
        cpu_rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (rsel_q == IW'(i)) begin
                cpu_rdata = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_map_decoder.sv
// Randomised and directed checks of mem_map_decoder against an address-range reference model.
module tb_mem_map_decoder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_we, cpu_re, err_clr;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic [3:0]  slv_we, slv_re;
    logic [31:0] slv_rdata;
    logic        err_flag;
    logic [15:0] err_addr;

    logic        ov_ready;
    logic [7:0]  ov_rdata;
    logic [1:0]  ov_we, ov_re;
    logic [15:0] ov_slv_rdata;
    logic        ov_err_flag;
    logic [15:0] ov_err_addr;

    mem_map_decoder u_dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .slv_we(slv_we), .slv_re(slv_re),
        .slv_rdata(slv_rdata), .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
    );

    mem_map_decoder #(
        .N_REG(2),
        .REG_BASE({16'h0000, 16'h0000}),
        .REG_LIMIT({16'h00FF, 16'h00FF}),
        .REG_WAIT({4'd0, 4'd0})
    ) u_ov (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_ready(ov_ready), .cpu_rdata(ov_rdata), .slv_we(ov_we), .slv_re(ov_re),
        .slv_rdata(ov_slv_rdata), .err_clr(err_clr), .err_flag(ov_err_flag), .err_addr(ov_err_addr)
    );

    // Reference memory map.
    int base_a [4] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
    int lim_a  [4] = '{32'h07FF, 32'h10FF, 32'h2960, 32'h30FF};
    int wait_a [4] = '{0, 0, 2, 1};

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          m_err;
    logic [15:0] m_eaddr;
    int          m_rsrc;

    function automatic int region_of(input logic [15:0] a);
        for (int i = 0; i < 4; i++)
            if (int'(a) >= base_a[i] && int'(a) <= lim_a[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_rdata();
        if (m_rsrc < 0) return 8'h00;
        return slv_rdata[m_rsrc*8 +: 8];
    endfunction

    task automatic model_reset();
        m_err   = 1'b0;
        m_eaddr = 16'h0000;
        m_rsrc  = -1;
    endtask

    // One complete access followed by an idle cycle that checks data and error state.
    task automatic acc(input logic [15:0] a, input logic we, input logic re, input logic clr);
        int r, w;
        logic [3:0] ew, er;
        r = region_of(a);
        w = (r >= 0) ? wait_a[r] : 0;
        cpu_addr = a; cpu_we = we; cpu_re = re; err_clr = clr;
        for (int c = 0; c <= w; c++) begin
            @(negedge clk);
            ew = (c == w && r >= 0 && we)        ? 4'(1 << r) : 4'd0;
            er = (c == w && r >= 0 && re && !we) ? 4'(1 << r) : 4'd0;
            n_chk++;
            if (cpu_ready !== (c == w)) $display("FAIL ready addr=%h cyc=%0d: got %b want %b", a, c, cpu_ready, c == w);
            else n_pass++;
            n_chk++;
            if (slv_we !== ew) $display("FAIL slv_we addr=%h cyc=%0d: got %b want %b", a, c, slv_we, ew);
            else n_pass++;
            n_chk++;
            if (slv_re !== er) $display("FAIL slv_re addr=%h cyc=%0d: got %b want %b", a, c, slv_re, er);
            else n_pass++;
            @(posedge clk); #1;
        end
        if (r < 0) begin
            m_err = 1'b1; m_eaddr = a;
        end else if (clr) begin
            m_err = 1'b0;
        end
        if (re && !we) m_rsrc = r;
        cpu_we = 1'b0; cpu_re = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cpu_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", cpu_ready);
        else n_pass++;
        n_chk++;
        if (cpu_rdata !== exp_rdata()) $display("FAIL rdata addr=%h: got %h want %h", a, cpu_rdata, exp_rdata());
        else n_pass++;
        n_chk++;
        if (err_flag !== m_err) $display("FAIL err_flag addr=%h: got %b want %b", a, err_flag, m_err);
        else n_pass++;
        n_chk++;
        if (err_addr !== m_eaddr) $display("FAIL err_addr addr=%h: got %h want %h", a, err_addr, m_eaddr);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_addr = 16'h0000; cpu_we = 1'b1; cpu_re = 1'b0; err_clr = 1'b0;
        slv_rdata = 32'hDEADBEEF; ov_slv_rdata = 16'h1234;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (cpu_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", cpu_ready);
        else n_pass++;
        n_chk++;
        if (slv_we !== 4'd0 || slv_re !== 4'd0) $display("FAIL rst_strobes: got %b/%b want 0/0", slv_we, slv_re);
        else n_pass++;
        n_chk++;
        if (cpu_rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", cpu_rdata);
        else n_pass++;
        n_chk++;
        if (err_flag !== 1'b0 || err_addr !== 16'h0000) $display("FAIL rst_err: got %b/%h want 0/0000", err_flag, err_addr);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; cpu_we = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        acc(16'h0123, 1'b1, 1'b0, 1'b0);
        slv_rdata = 32'h0000_A500;
        acc(16'h1005, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (cpu_rdata !== 8'hA5) $display("FAIL basic_rdata: got %h want a5", cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        slv_rdata = 32'h11_5C_22_33;
        acc(16'h2100, 1'b0, 1'b1, 1'b0);
        acc(16'h2960, 1'b1, 1'b0, 1'b0);
        acc(16'h30FF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_unmapped();
        acc(16'h0800, 1'b1, 1'b0, 1'b0);
        acc(16'h0800, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_err_clr();
        acc(16'h4000, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        n_chk++;
        if (err_flag !== 1'b0) $display("FAIL errclr_flag: got %b want 0", err_flag);
        else n_pass++;
        n_chk++;
        if (err_addr !== 16'h4000) $display("FAIL errclr_addr: got %h want 4000", err_addr);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_in_wait();
        acc(16'h5555, 1'b1, 1'b0, 1'b0);
        cpu_addr = 16'h3000; cpu_re = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cpu_ready !== 1'b0 || slv_re !== 4'd0) $display("FAIL rstwait_entry: got %b/%b want 0/0000", cpu_ready, slv_re);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cpu_ready !== 1'b0 || slv_re !== 4'd0 || slv_we !== 4'd0)
            $display("FAIL rstwait_cycle: got %b/%b/%b want 0/0000/0000", cpu_ready, slv_re, slv_we);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; cpu_re = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++;
        if (slv_re !== 4'd0 || slv_we !== 4'd0 || cpu_ready !== 1'b0)
            $display("FAIL rstwait_after: got %b/%b/%b want 0000/0000/0", slv_re, slv_we, cpu_ready);
        else n_pass++;
        n_chk++;
        if (err_flag !== 1'b0 || err_addr !== 16'h0000 || cpu_rdata !== 8'h00)
            $display("FAIL rstwait_state: got %b/%h/%h want 0/0000/00", err_flag, err_addr, cpu_rdata);
        else n_pass++;
        @(posedge clk); #1;
        acc(16'h3000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_we_re_overlap();
        acc(16'h0010, 1'b1, 1'b1, 1'b0);
        ov_slv_rdata = 16'hBBAA;
        cpu_addr = 16'h0040; cpu_we = 1'b1; cpu_re = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov_we !== 2'b01 || ov_re !== 2'b00 || ov_ready !== 1'b1)
            $display("FAIL overlap_we: got %b/%b/%b want 01/00/1", ov_we, ov_re, ov_ready);
        else n_pass++;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ov_re !== 2'b01 || ov_we !== 2'b00) $display("FAIL overlap_re: got %b/%b want 01/00", ov_re, ov_we);
        else n_pass++;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        m_rsrc = 0;
        @(negedge clk);
        n_chk++;
        if (ov_rdata !== 8'hAA) $display("FAIL overlap_rdata: got %h want aa", ov_rdata);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] edges [13] = '{16'h0000, 16'h07FF, 16'h0800, 16'h1000, 16'h10FF, 16'h1100,
                                    16'h2000, 16'h2960, 16'h2961, 16'h3000, 16'h30FF, 16'h3100, 16'hFFFF};
        logic [15:0] a;
        logic [1:0]  sel;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) a = edges[$urandom_range(0, 12)];
            else a = 16'($urandom_range(0, 16'h3FFF));
            sel = 2'($urandom_range(1, 3));
            slv_rdata = $urandom;
            acc(a, sel[0], sel[1], $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wait_states();
        test_unmapped();
        test_err_clr();
        test_rst_in_wait();
        test_we_re_overlap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
